// File: rtl/add_sub_serial.sv
// -----------------------------------------------------------------------------
// add_sub_serial
//   Digit-serial adder/subtractor. An operation is accepted on start_in, then
//   processed DIGIT bits per clock (LSB digit first) over N = WIDTH/DIGIT BUSY
//   cycles. The result and flags are written only on the edge that enters DONE,
//   so partially computed digits never reach the outputs.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 2)
//   DIGIT        bits processed per clock (1..WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk_in       clock, rising edge active
//   rst_n_in     asynchronous active-low reset
//   start_in     request to begin an operation (accepted in IDLE or DONE)
//   a_in, b_in   operands A and B
//   control_in   0 = A+B, 1 = A-B
//   busy_out     high while the operation is in progress
//   done_out     one-cycle pulse, result valid
//   result_out   sum or difference modulo 2^WIDTH
//   carry_out    unsigned carry; for subtract, 1 = no borrow
//   overflow_out two's-complement signed overflow
//   zero_out     result_out == 0
// -----------------------------------------------------------------------------
module add_sub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             control_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] result_out,
   output logic             carry_out,
   output logic             overflow_out,
   output logic             zero_out
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;      // operand A, shifted right one digit per cycle
   logic [WIDTH-1:0] b_sh;      // operand B, shifted right one digit per cycle
   logic [WIDTH-1:0] acc;       // result digits, shifted in from the top
   logic             ctrl;      // captured control_in
   logic             carry;     // carry between digits
   logic [CNT_W-1:0] cnt;       // index of the digit being computed
   logic             a_msb;     // A[MSB], kept for the overflow flag
   logic             bx_msb;    // (B XOR ctrl)[MSB], kept for the overflow flag

   logic [DIGIT-1:0] a_digit;
   logic [DIGIT-1:0] b_digit;
   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] acc_next;
   logic             last_digit;

   // NOTE: every signal written in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the missing cases.
   always_comb begin
      a_digit    = a_sh[DIGIT-1:0];
      b_digit    = b_sh[DIGIT-1:0] ^ {DIGIT{ctrl}};
      digit_sum  = {1'b0, a_digit} + {1'b0, b_digit} + (DIGIT+1)'(carry);
      // New digit enters at the top; after N shifts the word is in place.
      acc_next   = (acc >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
      last_digit = (cnt == CNT_W'(N - 1));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= IDLE;
         a_sh         <= '0;
         b_sh         <= '0;
         acc          <= '0;
         ctrl         <= 1'b0;
         carry        <= 1'b0;
         cnt          <= '0;
         a_msb        <= 1'b0;
         bx_msb       <= 1'b0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         result_out   <= '0;
         carry_out    <= 1'b0;
         overflow_out <= 1'b0;
         zero_out     <= 1'b0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_in) begin
                  a_sh     <= a_in;
                  b_sh     <= b_in;
                  acc      <= '0;
                  ctrl     <= control_in;
                  carry    <= control_in;   // +1 completes the two's complement of B
                  cnt      <= '0;
                  a_msb    <= a_in[WIDTH-1];
                  bx_msb   <= b_in[WIDTH-1] ^ control_in;
                  busy_out <= 1'b1;
                  state    <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end

            BUSY: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               acc   <= acc_next;
               carry <= digit_sum[DIGIT];
               if (last_digit) begin
                  busy_out     <= 1'b0;
                  done_out     <= 1'b1;
                  result_out   <= acc_next;
                  carry_out    <= digit_sum[DIGIT];
                  overflow_out <= (a_msb == bx_msb) && (acc_next[WIDTH-1] != a_msb);
                  zero_out     <= (acc_next == '0);
                  state        <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               busy_out <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/add_sub_serial.md
ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per clock cycle.
- Range: 1..WIDTH.
- WIDTH SHALL be an integer multiple of DIGIT.
- N = WIDTH/DIGIT.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock, rising edge active.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start_in, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port a_in, input, WIDTH bits: operand A.
REQ-007 SHALL have port b_in, input, WIDTH bits: operand B.
REQ-008 SHALL have port control_in, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-009 SHALL have port busy_out, output, 1 bit: high while the operation is in progress.
REQ-010 SHALL have port done_out, output, 1 bit: one-cycle pulse, result valid.
REQ-011 SHALL have port result_out, output, WIDTH bits: sum or difference, modulo 2^WIDTH.
REQ-012 SHALL have port carry_out, output, 1 bit: unsigned carry; for subtract, 1 = no borrow.
REQ-013 SHALL have port overflow_out, output, 1 bit: two's-complement signed overflow.
REQ-014 SHALL have port zero_out, output, 1 bit: result_out == 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 SHALL accept start_in only in IDLE or DONE.
- On acceptance at edge E: capture a_in, b_in, control_in; preset internal carry = control_in; clear digit counter; enter BUSY.
REQ-017 SHALL ignore start_in and any operand or control changes while in BUSY.
REQ-018 SHALL, in BUSY, compute digit i (LSB first) at edge E+1+i as:
- A[i] + (B[i] XOR {DIGIT{ctrl}}) + carry;
- store the digit sum and update carry with the digit carry.
REQ-019 SHALL, at edge E+N, write the final digit and enter DONE.
- done_out SHALL be high for exactly the one cycle spent in DONE.
- Latency from the accepting edge to done_out high SHALL be N edges.
REQ-020 SHALL update result_out, carry_out, overflow_out and zero_out only at the edge entering DONE.
- Partial digits SHALL never be visible on outputs.
- Outputs SHALL hold their value until the next DONE entry.
REQ-021 SHALL set overflow_out = (A[MSB] == B'[MSB]) AND (R[MSB] != A[MSB]), where B' = B XOR {WIDTH{ctrl}}.
REQ-022 SHALL drive busy_out high exactly when in BUSY; it SHALL be low in IDLE and DONE.
REQ-023 SHALL go from DONE to IDLE on the next edge when start_in is low.
- When start_in is high in DONE, SHALL go directly to BUSY (back-to-back operation, period N+1 cycles).
REQ-024 SHALL, when N = 1, complete in one BUSY cycle with the same handshake.

Reset
REQ-025 SHALL, while rst_n_in is low, immediately force:
- state IDLE;
- busy_out, done_out, result_out, carry_out, overflow_out and zero_out all 0;
- internal counter, carry and operand registers to 0.
REQ-026 SHALL abort an in-progress operation when reset is asserted in BUSY.
- No done_out pulse SHALL be produced for the aborted operation.
- The first start_in after reset release SHALL be accepted normally.

Verification
REQ-027 SHALL cover WIDTH=8, DIGIT=4, add 0x5A+0x6D:
- result_out=0xC7, carry_out=0, overflow_out=1, zero_out=0;
- done_out high 2 edges after the accepting edge; busy_out high for 2 cycles.
REQ-028 SHALL cover WIDTH=8, DIGIT=4, subtract 0x5A-0x6D:
- result_out=0xED, carry_out=0, overflow_out=0, zero_out=0.
REQ-029 SHALL cover WIDTH=8, DIGIT=4, subtract 0x3C-0x3C and add 0xFF+0x01:
- each gives result_out=0x00, carry_out=1, zero_out=1, overflow_out=0.
REQ-030 SHALL cover WIDTH=4, DIGIT=1:
- add 0xA+0xD -> result_out=0x7, carry_out=1, overflow_out=1, done_out 4 edges after accept;
- subtract 0xA-0xD -> result_out=0xD, carry_out=0, overflow_out=0.
REQ-031 SHALL cover handshake corner cases:
- start_in pulsed with new operands during BUSY -> ignored, result reflects the original operands;
- start_in high during the DONE cycle -> busy_out high the next cycle and a second done_out N+1 cycles after the first.
REQ-032 SHALL cover reset mid-operation:
- rst_n_in low 1 cycle after accept -> all outputs 0 at once and no done_out;
- after release, 0x01+0x01 -> result_out=0x02.
